// File: rtl/n64_pkg.sv
// Shared N64 line-protocol definitions: FSM states, default timing base,
// phase multipliers used by both the transmitter and the receiver.
package n64_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    STOP = 2'd3
  } n64_state_e;

  localparam int CYCLES_PER_US_DEF = 50;

  // Phase lengths in units of one microsecond
  localparam int MUL_SHORT = 1;
  localparam int MUL_STOP  = 2;
  localparam int MUL_LONG  = 3;

  // 0 and anything above 32 mean a full 32-bit frame
  function automatic logic [5:0] clamp_bits(input logic [5:0] n);
    return ((n == 6'd0) || (n > 6'd32)) ? 6'd32 : n;
  endfunction

endpackage

// File: rtl/n64_line_sync.sv
// Two-flop synchronizer for the open-drain line readback.
// Resets to 1 so the idle (pulled-up) line never looks like a collision.
module n64_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  // Two-stage metastability filter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/n64_transmit_controller_data.sv
// N64 controller response transmitter: sends up to 32 payload bits MSB first
// with pulse-width encoding, then the 2us stop bit, on an open-drain line.
// Optional feature macro: N64_TX_COLLISION_CHECK_EN (line readback abort).
module n64_transmit_controller_data
  import n64_pkg::*;
#(
  parameter int CYCLES_PER_US = CYCLES_PER_US_DEF
) (
  input  logic        sys_clk_i,
  input  logic        rst_i,
  input  logic        trigger_i,
  input  logic [31:0] controller_data_i,
  input  logic [5:0]  num_bits_i,
  input  logic        n64d_i,
  output logic        n64d_oe_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  localparam logic [7:0] LEN_SHORT = 8'(CYCLES_PER_US * MUL_SHORT);
  localparam logic [7:0] LEN_STOP  = 8'(CYCLES_PER_US * MUL_STOP);
  localparam logic [7:0] LEN_LONG  = 8'(CYCLES_PER_US * MUL_LONG);

  n64_state_e  state_q;
  logic [7:0]  cnt_q;
  logic [31:0] shreg_q;
  logic [5:0]  rem_q;
  logic        oe_q, busy_q, done_q, err_q;
  logic [7:0]  low_len, high_len;
  logic        collide;

  // A '1' is short-low/long-high, a '0' the reverse
  assign low_len  = shreg_q[31] ? LEN_SHORT : LEN_LONG;
  assign high_len = shreg_q[31] ? LEN_LONG  : LEN_SHORT;

`ifdef N64_TX_COLLISION_CHECK_EN
  logic line_s;

  n64_line_sync u_sync (
    .clk_i (sys_clk_i),
    .rst_i (rst_i),
    .d_i   (n64d_i),
    .q_o   (line_s)
  );

  // Someone else pulling low while we release; skip the first cycles so the
  // synchronizer has flushed our own low phase
  assign collide = (state_q == HIGH) && (cnt_q >= 8'd4) && !line_s;
`else
  logic unused_n64d;
  assign unused_n64d = n64d_i;
  assign collide     = 1'b0;
`endif

  // Frame sequencer with registered line/status outputs
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      shreg_q <= 32'd0;
      rem_q   <= 6'd0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // No re-arm in the done cycle
          if (trigger_i && !done_q) begin
            shreg_q <= controller_data_i;
            rem_q   <= clamp_bits(num_bits_i);
            cnt_q   <= 8'd0;
            oe_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= LOW;
          end
        end
        LOW: begin
          if (cnt_q == low_len - 8'd1) begin
            cnt_q   <= 8'd0;
            oe_q    <= 1'b0;
            state_q <= HIGH;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        HIGH: begin
          if (collide) begin
            cnt_q   <= 8'd0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else if (cnt_q == high_len - 8'd1) begin
            cnt_q   <= 8'd0;
            shreg_q <= {shreg_q[30:0], 1'b0};
            rem_q   <= rem_q - 6'd1;
            oe_q    <= 1'b1;
            state_q <= (rem_q == 6'd1) ? STOP : LOW;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        STOP: begin
          if (cnt_q == LEN_STOP - 8'd1) begin
            cnt_q   <= 8'd0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign n64d_oe_o = oe_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
`ifdef N64_TX_COLLISION_CHECK_EN
  assign error_o   = err_q;
`else
  assign error_o   = 1'b0;
`endif

endmodule

// File: doc/n64_transmit_controller_data.md
# n64_transmit_controller_data

Drives an N64 controller response frame onto the open-drain data line. The frame carries up to 32 bits of button/identity data, MSB first, followed by the controller stop bit. The block is the transmit counterpart of the controller-data receiver and uses the same pulse-width encoding at the same sys_clk rate. It sits between the controller-emulation logic, which supplies the data word and a start strobe, and the bidirectional pad, where n64d_oe pulls the line low.

## Interface
- CYCLES_PER_US, 50: sys_clk cycles per microsecond; every phase length is derived from it. Legal range is 8..63, so all phase counts fit the 8-bit counter.
- sys_clk  in  1  sole clock; every register is on posedge
- rst  in  1  asynchronous, active-high reset
- trigger  in  1  single-cycle start strobe; ignored while busy
- controller_data  in  32  frame payload, sampled on the trigger cycle; bit 31 is sent first
- num_bits  in  6  payload length, sampled on the trigger cycle; 1..32 are used as-is, 0 or >32 are treated as 32
- n64d  in  1  line readback; used only when the collision check is compiled in
- n64d_oe  out  1  registered; 1 = pull the line low, 0 = release it (pad pull-up)
- busy  out  1  high from the cycle after an accepted trigger through the final cycle of the frame
- done  out  1  one-cycle pulse when a frame completes normally
- error  out  1  one-cycle pulse when a frame is aborted (collision build only)

## Operation
- Bit encoding (T = CYCLES_PER_US):
  - '0' = 3T low, then 1T high.
  - '1' = 1T low, then 3T high.
  - Stop = 2T low, then release.
  - No idle gap between bits.
- States:
  - IDLE: on trigger, latch the data shift register and the length, clear the counter, go to LOW.
  - LOW: drive low until the counter reaches the low length for the current bit, then go to HIGH.
  - HIGH: release until the counter reaches the high length. Then shift and decrement the remaining count. If bits remain, go to LOW; otherwise go to STOP.
  - STOP: drive low for 2T, then release and go to IDLE, pulsing done.
- Phase counter: 8 bits, unsigned, cleared at each phase transition. It never wraps, because the longest phase (3T = 150 at default) is below 256.
- Length handling: the remaining-bit counter is 6 bits, loaded with the clamped num_bits, and counts down to 0.
- Trigger while busy: ignored, with no effect on the frame in flight. Trigger in the same cycle that done is asserted: also ignored; the block re-arms on the following cycle.
- controller_data and num_bits changing mid-frame have no effect, because both are latched at trigger.

## Timing
- Reset values: n64d_oe=0, busy=0, done=0, error=0, state=IDLE. Assertion of rst releases the line immediately.
- Trigger accepted at cycle C:
  - n64d_oe=1 and busy=1 from cycle C+1.
  - First falling edge at C+1.
- Each bit occupies exactly 4T cycles. A 32-bit frame lasts 32·4T + 2T = 6500 cycles at T=50.
- At the end of the stop bit, done=1 and n64d_oe=0 in the same cycle, and busy=0 in that cycle.
- Minimum trigger-to-trigger spacing is frame length + 1 cycle.

## Configuration
- N64_TX_COLLISION_CHECK_EN
  - Defined:
    - n64d passes through a 2-flop synchronizer.
    - In HIGH, after 4 settling cycles, any synchronized low sample aborts the frame: n64d_oe=0, state returns to IDLE, error pulses for one cycle, busy=0 in the same cycle, and done is not pulsed.
  - Undefined: n64d is unused, error is tied to 0, and no synchronizer is instantiated.

## Structure
- Package n64_pkg holds:
  - the state enum (IDLE/LOW/HIGH/STOP);
  - the default CYCLES_PER_US=50;
  - the phase multipliers (1, 2, 3) shared with the receiver.

  Absolute phase lengths are computed locally from the parameter.
- Sub-module n64_line_sync (2-flop synchronizer with async reset) is instantiated only under N64_TX_COLLISION_CHECK_EN.

## Test plan
- Reset, idle: hold rst 5 cycles, then idle 100 cycles -> n64d_oe, busy, done, error all 0.
- Full frame: trigger with controller_data=32'hA000_0001 and num_bits=32.
  - Low widths are 50, 150, 50, 150, ... for the leading bits.
  - The final bit is low 50.
  - The stop bit is low 100.
  - done arrives 6500 cycles after C+1.
  - A loopback receiver reports 32'hA000_0001.
- Short and clamped lengths:
  - num_bits=24 with 32'h0500_02FF -> 24 bits (0x050002) plus stop, 4900 cycles.
  - num_bits=0 -> 32-bit frame.
- Trigger while busy: second trigger at cycle 1000 -> waveform is identical to the single-trigger run, with one done.
- Reset mid-frame: assert rst during LOW of bit 5 -> n64d_oe=0 immediately, busy=0, no done; the next trigger sends a clean full frame.
- Collision (macro defined): force n64d=0 for 10 cycles during the HIGH of bit 3, starting 20 cycles in -> error pulses once, n64d_oe=0, busy=0, no done.
